// File: rtl/mesh_inject_tx.sv
// Mesh injection transmitter: buffers dest/payload requests, packs hop fields and drives a 4-phase req/ack channel.
// Latency: push at edge N gives out_req high after edge N+2 when idle; each flit takes >= 4 + 2*SYNC_STAGES cycles.
// Backpressure: in_ready drops while the input FIFO is full; the channel is paced by the synchronised out_ack.

module mesh_inject_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module mesh_inject_tx #(
  parameter int WIDTH       = 15,
  parameter int X_HOP_LOC   = 4,
  parameter int Y_HOP_LOC   = 7,
  parameter int ROW         = 4,
  parameter int COL         = 4,
  parameter int SRC_ROW     = 3,
  parameter int SRC_COL     = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_dest,
  input  logic [WIDTH-7:0] in_payload,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic             busy,
  output logic [15:0]      pkt_count
);
  localparam int PW = WIDTH - 6;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t state, state_nxt;
  logic [1:0] rst_pipe;
  logic rst_sync_n;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic ack_s;
  logic [3:0] dest_row, dest_col;
  logic signed [4:0] dx, dy;
  logic [WIDTH-1:0] push_flit, fifo_dout;
  logic fifo_full, fifo_empty, push, pop;
  logic req_set, req_clr, cnt_inc;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) ack_sync <= '0;
    else             ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  function automatic logic [2:0] hop_field(input logic signed [4:0] d);
    logic [4:0] mag;
    mag = (d < 0) ? 5'(-d) : 5'(d);
    return {(d < 0), mag[1:0]};
  endfunction

  assign dest_row = in_dest / 4'(COL);
  assign dest_col = in_dest % 4'(COL);
  assign dx = $signed({1'b0, dest_col}) - $signed(5'(SRC_COL));
  assign dy = $signed({1'b0, dest_row}) - $signed(5'(SRC_ROW));

  always_comb begin
    push_flit                         = '0;
    push_flit[Y_HOP_LOC +: 3]         = hop_field(dy);
    push_flit[X_HOP_LOC +: 3]         = hop_field(dx);
    push_flit[X_HOP_LOC-1:0]          = in_payload[X_HOP_LOC-1:0];
    push_flit[WIDTH-1:Y_HOP_LOC+3]    = in_payload[PW-1:X_HOP_LOC];
  end

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  mesh_inject_fifo #(.W(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .push  (push),
    .din   (push_flit),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // IDLE also waits for a low ack so a stale ack is never mistaken for a new one.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !ack_s) begin
        pop       = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        req_set   = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: if (ack_s) begin
        req_clr   = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: if (!ack_s) begin
        cnt_inc   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_req   <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      if (req_set)      out_req <= 1'b1;
      else if (req_clr) out_req <= 1'b0;
      if (pop)     out_data  <= fifo_dout;
      if (cnt_inc) pkt_count <= pkt_count + 16'd1;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mesh_inject_tx.sv
// Bench for mesh_inject_tx: directed pushes with hand-packed flits feed a scoreboard queue,
// a monitor pops on each out_req rise, and an ack responder plays the mesh side.
module tb_mesh_inject_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dest = '0;
  logic [8:0]  in_payload = '0;
  logic        out_req;
  logic [14:0] out_data;
  logic        out_ack;
  logic        busy;
  logic [15:0] pkt_count;

  mesh_inject_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dest    (in_dest),
    .in_payload (in_payload),
    .out_req    (out_req),
    .out_data   (out_data),
    .out_ack    (out_ack),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_total = 0, m_bad = 0;
  logic [14:0] exp_q [$];

  logic ack_auto = 1'b1, ack_manual = 1'b0, hold_ack = 1'b0, rand_ack = 1'b0;
  int   fix_dly = 2;

  // dest, payload, hand-packed flit
  logic [3:0]  vd [6] = '{4'd0, 4'd15, 4'd10, 4'd6, 4'd13, 4'd4};
  logic [8:0]  vp [6] = '{9'h000, 9'h001, 9'h0F0, 9'h100, 9'h00A, 9'h055};
  logic [14:0] ve [6] = '{15'h0380, 15'h0031, 15'h3EA0, 15'h4320, 15'h001A, 15'h1705};

  function automatic int pick_dly();
    return rand_ack ? int'($urandom_range(0, 20)) : fix_dly;
  endfunction

  // Mesh-side responder; the only driver of out_ack.
  initial begin
    int n;
    out_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!ack_auto) out_ack = ack_manual;
      else if (out_req && !out_ack && !hold_ack) begin
        n = pick_dly();
        repeat (n) begin @(posedge clk); #2; end
        out_ack = 1'b1;
      end else if (!out_req && out_ack) begin
        n = pick_dly();
        repeat (n) begin @(posedge clk); #2; end
        out_ack = 1'b0;
      end
    end
  end

  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [14:0] prev_data = '0, mon_exp;
  int          cyc = 0, last_fall = -100;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (prev_req || prev_ack || out_req) begin
          m_total++;
          if (out_data !== prev_data) begin
            m_bad++;
            $display("FAIL data_stable: out_data=%h was %h during handshake", out_data, prev_data);
          end
        end
        if (prev_ack && !out_ack) last_fall = cyc;
        if (out_req && !prev_req) begin
          m_total++;
          if (exp_q.size() == 0) begin
            m_bad++;
            $display("FAIL flit_unexpected: out_data=%h with empty scoreboard", out_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
              m_bad++;
              $display("FAIL flit_data: out_data=%h expected %h", out_data, mon_exp);
            end
          end
          m_total++;
          if (out_ack || (cyc - last_fall) < 3) begin
            m_bad++;
            $display("FAIL req_rerise: ack=%0b gap=%0d expected ack=0 gap>=3", out_ack, cyc - last_fall);
          end
        end
      end
      prev_req  = rst_n ? out_req : 1'b0;
      prev_ack  = out_ack;
      prev_data = out_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [8:0] p, input logic [14:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_dest = d;
    in_payload = p;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    chk("push_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      @(negedge clk);
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_req || out_ack) && n < 3000) begin @(negedge clk); n++; end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #13;
    chk("rst_req",   {31'd0, out_req}, 32'd0);
    chk("rst_data",  {17'd0, out_data}, 32'd0);
    chk("rst_cnt",   {16'd0, pkt_count}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First flit and its latency
    push(4'd5, 9'h1A5, 15'h6B15);
    chk("lat_n0", {31'd0, out_req}, 32'd0);
    @(negedge clk);
    chk("lat_n1", {31'd0, out_req}, 32'd0);
    @(negedge clk);
    chk("lat_n2", {31'd0, out_req}, 32'd1);
    chk("data1", {17'd0, out_data}, 32'h6B15);
    wait_idle();
    chk("cnt1", {16'd0, pkt_count}, 32'd1);

    push(4'd3, 9'h1FF, 15'h7FBF);
    push(4'd12, 9'h000, 15'h0000);
    wait_idle();
    chk("cnt3", {16'd0, pkt_count}, 32'd3);

    // Fill: one flit stalled on the channel plus four buffered
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++) push(vd[i], vp[i], ve[i]);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_dest = vd[5];
    in_payload = vp[5];
    repeat (3) @(negedge clk);
    chk("held_ready", {31'd0, in_ready}, 32'd0);
    chk("held_busy", {31'd0, busy}, 32'd1);
    hold_ack = 1'b0;
    push(vd[5], vp[5], ve[5]);
    wait_idle();
    chk("cnt9", {16'd0, pkt_count}, 32'd9);
    chk("drain_q", exp_q.size(), 32'd0);

    // Random ack timing
    rand_ack = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) push(vd[i], vp[i], ve[i]);
    wait_idle();
    chk("cnt21", {16'd0, pkt_count}, 32'd21);
    chk("rand_q", exp_q.size(), 32'd0);
    rand_ack = 1'b0;

    // Reset in WAIT_HI with ack high, then stale ack after release
    ack_manual = 1'b0;
    ack_auto = 1'b0;
    push(vd[0], vp[0], ve[0]);
    push(vd[1], vp[1], ve[1]);
    for (int n = 0; n < 50 && !out_req; n++) @(negedge clk);
    chk("rst_test_req", {31'd0, out_req}, 32'd1);
    ack_manual = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, out_req}, 32'd0);
    chk("mid_rst_data",  {17'd0, out_data}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_cnt",   {16'd0, pkt_count}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    push(vd[2], vp[2], ve[2]);
    repeat (10) @(negedge clk);
    chk("stale_ack_no_req", {31'd0, out_req}, 32'd0);
    fix_dly = 3;
    ack_auto = 1'b1;
    wait_idle();
    chk("cnt_after_rst", {16'd0, pkt_count}, 32'd1);
    chk("rst_q", exp_q.size(), 32'd0);

    // Counter wrap
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count;
    @(negedge clk);
    push(vd[3], vp[3], ve[3]);
    wait_idle();
    chk("cnt_wrap", {16'd0, pkt_count}, 32'd0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total + m_total, bad + m_bad);
    $finish;
  end
endmodule
